// File: rtl/divider_sequencer.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring divider sequenced by an FSM,
// with RISC-V divide-by-zero and signed-overflow results resolved at accept.
module divider_sequencer #(
    parameter int         WIDTH    = 32,
    parameter int         COUNT_W  = 6,
    parameter logic [4:0] ALU_DIV  = 5'd12,
    parameter logic [4:0] ALU_DIVU = 5'd13,
    parameter logic [4:0] ALU_REM  = 5'd14,
    parameter logic [4:0] ALU_REMU = 5'd15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_function,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             state, next_state;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   dq;        // dividend shifts out MSB-first while quotient bits shift in
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem;
    logic               sel_rem;
    logic               neg_q;
    logic               neg_r;

    // Request decode and special-case resolution
    logic             is_div, is_divu, is_rem, is_remu;
    logic             op_valid, op_signed, op_rem;
    logic             a_neg, b_neg, div_by_zero, overflow, special, accept;
    logic [WIDTH-1:0] a_mag, b_mag, special_result;

    assign is_div      = (alu_function == ALU_DIV);
    assign is_divu     = (alu_function == ALU_DIVU);
    assign is_rem      = (alu_function == ALU_REM);
    assign is_remu     = (alu_function == ALU_REMU);
    assign op_valid    = is_div | is_divu | is_rem | is_remu;
    assign op_signed   = is_div | is_rem;
    assign op_rem      = is_rem | is_remu;
    assign a_neg       = op_signed & operand_a[WIDTH-1];
    assign b_neg       = op_signed & operand_b[WIDTH-1];
    assign a_mag       = a_neg ? -operand_a : operand_a;
    assign b_mag       = b_neg ? -operand_b : operand_b;
    assign div_by_zero = (operand_b == '0);
    assign overflow    = op_signed && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
    assign special     = div_by_zero | overflow;
    assign accept      = (state == IDLE) & start & op_valid & ~flush;

    always_comb begin
        if (div_by_zero)
            special_result = op_rem ? operand_a : '1;
        else
            special_result = op_rem ? '0 : operand_a;
    end

    // One restoring step. A set MSB after the shift already exceeds any 32-bit divisor;
    // otherwise the borrow of the 33-bit subtract decides.
    logic [WIDTH:0]   rem_shift, diff;
    logic             ge;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign rem_shift = {rem, dq[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor};
    assign ge        = rem_shift[WIDTH] | ~diff[WIDTH];
    assign q_fix     = neg_q ? -dq : dq;
    assign r_fix     = neg_r ? -rem : rem;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        next_state   = state;
        ready        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept)
                    next_state = special ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (flush)
                    next_state = IDLE;
                else if (count == COUNT_W'(WIDTH-1))
                    next_state = FIXUP;
            end
            FIXUP: begin
                busy       = 1'b1;
                next_state = flush ? IDLE : DONE;
            end
            DONE: begin
                result_valid = ~flush;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            dq      <= '0;
            divisor <= '0;
            rem     <= '0;
            sel_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            count   <= '0;
            dq      <= a_mag;
            divisor <= b_mag;
            rem     <= '0;
            sel_rem <= op_rem;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            if (special)
                result <= special_result;
        end else if (state == CALC) begin
            rem   <= ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            dq    <= {dq[WIDTH-2:0], ge};
            count <= count + COUNT_W'(1);
        end else if (state == FIXUP && !flush) begin
            result <= sel_rem ? r_fix : q_fix;
        end
    end

endmodule
